// File: rtl/requant_stage_pkg.sv
// Shared constants for the requantisation stage: lane count and default
// datapath widths used by the interface, the lane datapath and the top.
package requant_stage_pkg;

  // Number of parallel accumulator lanes fed by the convolution stage.
  localparam int PICTURE_NUM = 4;

  // Default datapath widths.
  localparam int ACC_W_DEF   = 32;
  localparam int SCALE_W_DEF = 16;
  localparam int OUT_W_DEF   = 8;

  // Width of the right-shift amount (0..31).
  localparam int SHIFT_W = 5;

endpackage

// File: rtl/requant_stage_if.sv
// Handshake bundle between the accumulation stage, the requant stage and the
// write-back consumer. The slave modport is the requant stage's view.
interface requant_stage_if #(
  parameter int LANES = requant_stage_pkg::PICTURE_NUM,
  parameter int ACC_W = requant_stage_pkg::ACC_W_DEF,
  parameter int OUT_W = requant_stage_pkg::OUT_W_DEF
);

  // Upstream side: accumulated sums plus their per-lane bias.
  logic                   s_valid;
  logic                   s_ready;
  logic [LANES*ACC_W-1:0] s_data;
  logic [LANES*ACC_W-1:0] bias;

  // Downstream side: quantised activations.
  logic                   m_valid;
  logic                   m_ready;
  logic [LANES*OUT_W-1:0] m_data;

  modport slave (
    input  s_valid, s_data, bias, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, bias, m_ready,
    input  s_ready, m_valid, m_data
  );

endinterface

// File: rtl/requant_lane.sv
// One lane of the requant pipeline:
//   S1 saturating bias add, S2 unsigned-scale multiply,
//   S3 round-half-up arithmetic shift, zero-point add, clamp to unsigned.
// All three stages advance together on en and hold otherwise.
module requant_lane
  import requant_stage_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int SCALE_W = SCALE_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic signed [ACC_W-1:0]   acc,
  input  logic signed [ACC_W-1:0]   bias,
  input  logic        [SCALE_W-1:0] scale,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic        [OUT_W-1:0]   zero_point,
  output logic        [OUT_W-1:0]   result
);

  // Product of a signed ACC_W value and a zero-extended SCALE_W value.
  localparam int PROD_W = ACC_W + SCALE_W + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic        [OUT_W-1:0] OUT_MAX = '1;

  logic signed [ACC_W:0]    sum_wide;
  logic signed [ACC_W-1:0]  sum_sat;
  logic signed [ACC_W-1:0]  sum_q;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [PROD_W-1:0] rnd;
  logic signed [PROD_W-1:0] rounded;
  logic signed [PROD_W:0]   offset;
  logic        [OUT_W-1:0]  result_d;

  // S1: bias add at ACC_W+1 bits, saturated back to ACC_W.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum_wide = {acc[ACC_W-1], acc} + {bias[ACC_W-1], bias};
    sum_sat  = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // S2: signed multiply by the unsigned scale; PROD_W bits cannot overflow.
  always_comb begin
    prod_d = PROD_W'(sum_q) * PROD_W'($signed({1'b0, scale}));
  end

  // S3: round half up, arithmetic shift, add zero point, clamp (fused ReLU).
  // The rounding add cannot overflow: |prod| < 2^(PROD_W-2) and rnd <= 2^30.
  always_comb begin
    rnd = '0;
    if (shift != '0) begin
      rnd = PROD_W'(1) << (shift - SHIFT_W'(1));
    end
    rounded  = (prod_q + rnd) >>> shift;
    offset   = (PROD_W+1)'(rounded) + (PROD_W+1)'($signed({1'b0, zero_point}));
    result_d = offset[OUT_W-1:0];
    if (offset[PROD_W]) begin
      result_d = '0;
    end else if (|offset[PROD_W-1:OUT_W]) begin
      result_d = OUT_MAX;
    end
  end

  // Pipeline data registers: cleared on reset, advance only when en is high.
  // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values.
  // NOTE: data registers are reset too, so m_data reads zero straight after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q  <= '0;
      prod_q <= '0;
      result <= '0;
    end else if (en) begin
      sum_q  <= sum_sat;
      prod_q <= prod_d;
      result <= result_d;
    end
  end

endmodule

// File: rtl/requant_stage.sv
// Requantisation stage: per-lane bias add, rescale, round/shift, zero-point
// offset and clamp to unsigned activations. Three-stage pipeline whose valid
// chain, enable and busy flag live here; the datapath is replicated per lane.
module requant_stage
  import requant_stage_pkg::*;
#(
  parameter int LANES   = PICTURE_NUM,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int SCALE_W = SCALE_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  requant_stage_if.slave     bus,
  input  logic [SCALE_W-1:0] scale,
  input  logic [SHIFT_W-1:0] shift,
  input  logic [OUT_W-1:0]   zero_point,
  output logic               busy
);

  logic [2:0]             vld;
  logic                   en;
  logic [LANES*OUT_W-1:0] m_data;

  // Whole pipeline moves unless the output word is valid and not taken.
  assign en          = ~vld[2] | bus.m_ready;
  assign bus.s_ready = en;
  assign bus.m_valid = vld[2];
  assign bus.m_data  = m_data;
  assign busy        = |vld;

  // Valid chain: one bit per stage; a bubble accepted while en=1 stays invalid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld <= '0;
    end else if (en) begin
      vld <= {vld[1:0], bus.s_valid};
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane #(
      .ACC_W  (ACC_W),
      .SCALE_W(SCALE_W),
      .OUT_W  (OUT_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .acc       (bus.s_data[i*ACC_W +: ACC_W]),
      .bias      (bus.bias[i*ACC_W +: ACC_W]),
      .scale     (scale),
      .shift     (shift),
      .zero_point(zero_point),
      .result    (m_data[i*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_requant_stage.sv
// Directed bench for requant_stage: a scoreboard queue is filled when a word
// is accepted and drained by a monitor on the falling edge when a word leaves.
module tb_requant_stage;
  import requant_stage_pkg::*;

  localparam int LANES   = PICTURE_NUM;
  localparam int ACC_W   = ACC_W_DEF;
  localparam int SCALE_W = SCALE_W_DEF;
  localparam int OUT_W   = OUT_W_DEF;
  localparam int SB_W    = LANES * OUT_W;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [SCALE_W-1:0] scale;
  logic [SHIFT_W-1:0] shift;
  logic [OUT_W-1:0]   zero_point;
  logic               busy;

  requant_stage_if #(.LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  requant_stage #(
    .LANES  (LANES),
    .ACC_W  (ACC_W),
    .SCALE_W(SCALE_W),
    .OUT_W  (OUT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .scale     (scale),
    .shift     (shift),
    .zero_point(zero_point),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int out_cnt = 0;
  logic [SB_W-1:0] sb[$];
  logic signed [ACC_W-1:0] acc_v[LANES];
  logic signed [ACC_W-1:0] bias_v[LANES];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference arithmetic on 64-bit integers, independent of the RTL widths.
  function automatic logic [OUT_W-1:0] model(input longint a, input longint b,
                                             input longint sc, input int sh,
                                             input longint zp);
    longint s, p, r, t, amax, amin, omax;
    amax = (longint'(1) << (ACC_W - 1)) - 1;
    amin = -amax - 1;
    omax = (longint'(1) << OUT_W) - 1;
    s = a + b;
    if (s > amax) s = amax;
    else if (s < amin) s = amin;
    p = s * sc;
    if (sh == 0) r = p;
    else r = (p + (longint'(1) << (sh - 1))) >>> sh;
    t = r + zp;
    if (t < 0) t = 0;
    else if (t > omax) t = omax;
    return OUT_W'(t);
  endfunction

  function automatic logic [SB_W-1:0] expect_word();
    logic [SB_W-1:0] e;
    e = '0;
    for (int i = 0; i < LANES; i++) begin
      e[i*OUT_W +: OUT_W] = model(longint'(acc_v[i]), longint'(bias_v[i]),
                                  longint'(scale), int'(shift), longint'(zero_point));
    end
    return e;
  endfunction

  task automatic load();
    for (int i = 0; i < LANES; i++) begin
      bus.s_data[i*ACC_W +: ACC_W] = acc_v[i];
      bus.bias[i*ACC_W +: ACC_W]   = bias_v[i];
    end
  endtask

  // Entered at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send();
    int guard;
    guard = 0;
    load();
    bus.s_valid = 1'b1;
    #1;
    while (!bus.s_ready && guard < 100) begin
      @(posedge clk); #2;
      guard++;
    end
    check("send_timeout", 64'(guard < 100), 64'd1);
    sb.push_back(expect_word());
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    idle();
    while (busy && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_timeout", 64'(guard < 100), 64'd1);
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  // Config changes only while idle, followed by a cycle without an accept.
  task automatic set_cfg(input int sc, input int sh, input int zp);
    scale      = SCALE_W'(sc);
    shift      = SHIFT_W'(sh);
    zero_point = OUT_W'(zp);
    @(posedge clk); #1;
  endtask

  // Output monitor: ready relation, stall stability and scoreboard compare.
  bit              mon_en = 1'b0;
  logic            prev_stall = 1'b0;
  logic            prev_rst = 1'b1;
  logic [SB_W-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("s_ready_rel", 64'(bus.s_ready), 64'(!(bus.m_valid && !bus.m_ready)));
      if (prev_stall && prev_rst) begin
        check("stall_hold_valid", 64'(bus.m_valid), 64'd1);
        check("stall_hold_data", 64'(bus.m_data), 64'(prev_data));
      end
      if (bus.m_valid && bus.m_ready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(bus.m_valid), 64'd0);
        end else begin
          logic [SB_W-1:0] e;
          e = sb.pop_front();
          for (int i = 0; i < LANES; i++) begin
            check($sformatf("out_lane%0d", i), 64'(bus.m_data[i*OUT_W +: OUT_W]),
                  64'(e[i*OUT_W +: OUT_W]));
          end
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_rst   = rst;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cyc, guard, cnt0;
    bit acc_now;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.bias     = '0;
    bus.m_ready  = 1'b1;
    scale        = 16'd3;
    shift        = 5'd4;
    zero_point   = '0;

    // Reset: three cycles low.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_m_data", 64'(bus.m_data), 64'd0);
    check("rst_s_ready", 64'(bus.s_ready), 64'd1);
    rst    = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Basic rescale with latency check: m_valid only in the third cycle after accept.
    acc_v  = '{1000, 50000, -20, 7};
    bias_v = '{24, -100, 3, 0};
    send();
    idle();
    @(negedge clk); check("lat_c1", 64'(bus.m_valid), 64'd0);
    @(negedge clk); check("lat_c2", 64'(bus.m_valid), 64'd0);
    @(negedge clk); check("lat_c3", 64'(bus.m_valid), 64'd1);
    check("basic_lane0", 64'(bus.m_data[OUT_W-1:0]), 64'd192);
    @(negedge clk); check("lat_c4", 64'(bus.m_valid), 64'd0);
    @(posedge clk); #1;
    drain();

    // Clamp: ReLU on negatives at scale 3 / shift 4.
    acc_v  = '{-500, -1, 0, 1};
    bias_v = '{0, 0, 0, 0};
    send();
    drain();

    // Clamp: upper saturation at unit scale.
    set_cfg(1, 0, 0);
    acc_v = '{100000, 255, 256, -3};
    send();
    drain();

    // Clamp: zero point pulls small negatives back into range.
    set_cfg(1, 0, 10);
    acc_v = '{-3, 245, 246, -11};
    send();
    drain();

    // Bias saturation in both directions with the maximum shift.
    set_cfg(1, 31, 0);
    acc_v  = '{32'sh7FFF_FFF0, 32'sh8000_0010, 32'sh4000_0000, -1};
    bias_v = '{32'sh0000_0100, -32'sh0000_0100, 32'sh4000_0000, 0};
    send();
    drain();

    // Back-pressure: ten words while m_ready follows 1,0,0,1 repeating.
    set_cfg(1, 0, 0);
    cnt0 = out_cnt;
    k = 0;
    cyc = 0;
    while ((k < 10 || sb.size() != 0 || busy) && cyc < 300) begin
      bus.m_ready = pat[cyc % 4];
      bus.s_valid = (k < 10);
      for (int i = 0; i < LANES; i++) begin
        acc_v[i]  = ACC_W'(k + 40 * i);
        bias_v[i] = '0;
      end
      load();
      #1;
      acc_now = bus.s_valid && bus.s_ready;
      if (acc_now) sb.push_back(expect_word());
      @(posedge clk); #1;
      if (acc_now) k++;
      cyc++;
    end
    check("bp_all_sent", 64'(k), 64'd10);
    check("bp_out_count", 64'(out_cnt - cnt0), 64'd10);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);
    bus.m_ready = 1'b1;
    idle();
    @(posedge clk); #1;

    // Reset mid-operation: two accepted words must never appear.
    cnt0 = out_cnt;
    acc_v  = '{11, 22, 33, 44};
    bias_v = '{0, 0, 0, 0};
    load();
    bus.s_valid = 1'b1;
    @(posedge clk); #1;
    acc_v = '{55, 66, 77, 88};
    load();
    @(posedge clk); #1;
    idle();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_m_data", 64'(bus.m_data), 64'd0);
    check("midrst_m_valid", 64'(bus.m_valid), 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("midrst_no_valid", 64'(bus.m_valid), 64'd0);
    end
    check("midrst_no_output", 64'(out_cnt - cnt0), 64'd0);
    @(posedge clk); #1;

    // Multi-lane independence: lane i gives min(17*i, 255).
    set_cfg(2, 1, 0);
    for (int i = 0; i < LANES; i++) begin
      acc_v[i]  = ACC_W'(i * 16);
      bias_v[i] = ACC_W'(i);
    end
    send();
    idle();
    guard = 0;
    @(negedge clk);
    while (!bus.m_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ml_timeout", 64'(guard < 20), 64'd1);
    for (int i = 0; i < LANES; i++) begin
      check($sformatf("ml_lane%0d", i), 64'(bus.m_data[i*OUT_W +: OUT_W]),
            64'((i * 17 > 255) ? 255 : i * 17));
    end
    @(posedge clk); #1;
    drain();

    check("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
